// File: rtl/tdc_hit_readout_if.sv
// Readout handshake between the hit FIFO and the downstream serializer / slow-control reader.
// The FIFO side (master) presents words; the consumer side (slave) accepts them with dataReady.
interface tdc_hit_readout_if;
    logic [39:0] dataOut;
    logic        dataValid;
    logic        dataReady;

    modport master (
        output dataOut,
        output dataValid,
        input  dataReady
    );

    modport slave (
        input  dataOut,
        input  dataValid,
        output dataReady
    );
endinterface

// File: rtl/tdc_hit_readout.sv
// TDC hit readout: TOA window filter, BCID tagging, 40-bit word packing and a small FIFO
// drained over a valid/ready handshake, with sticky/saturating drop accounting.
module tdc_hit_readout #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk40,
    input  logic          resetn,
    input  logic          enable,
    input  logic          bcReset,
    input  logic [9:0]    TOA_code,
    input  logic [8:0]    TOT_code,
    input  logic [9:0]    Cal_code,
    input  logic          hitFlag,
    input  logic          TOAerrorFlag,
    input  logic          TOTerrorFlag,
    input  logic          CalerrorFlag,
    input  logic [9:0]    winLow,
    input  logic [9:0]    winHigh,
    input  logic          clearOverflow,
    tdc_hit_readout_if.master rd,
    output logic [AW:0]   fifoCount,
    output logic          overflowFlag,
    output logic [7:0]    overflowCnt
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    bcid;
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [39:0]   mem [DEPTH];
    logic [39:0]   hitWord;
    logic          winOk;
    logic          push;
    logic          pop;
    logic          full;
    logic          doWrite;
    logic          drop;

    // An inverted window (winLow > winHigh) can never satisfy both bounds, so it rejects everything.
    assign winOk   = (TOA_code >= winLow) && (TOA_code <= winHigh);
    assign push    = hitFlag && enable && winOk;
    assign pop     = (fifoCount != '0) && rd.dataReady;
    assign full    = (fifoCount == FULL_COUNT);
    assign doWrite = push && (!full || pop);
    assign drop    = push && full && !pop;

    assign hitWord = {bcid, TOAerrorFlag, TOTerrorFlag, CalerrorFlag, TOA_code, TOT_code, Cal_code};

    assign rd.dataValid = (fifoCount != '0);
    assign rd.dataOut   = rd.dataValid ? mem[rdPtr] : '0;

    always_ff @(posedge clk40 or negedge resetn) begin
        if (!resetn) begin
            bcid <= '0;
        end else if (bcReset) begin
            bcid <= '0;
        end else begin
            bcid <= bcid + 8'd1;
        end
    end

    // Storage is deliberately left out of reset; occupancy alone decides what is valid.
    always_ff @(posedge clk40) begin
        if (doWrite) begin
            mem[wrPtr] <= hitWord;
        end
    end

    always_ff @(posedge clk40 or negedge resetn) begin
        if (!resetn) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (doWrite) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({doWrite, pop})
                2'b10:   fifoCount <= fifoCount + (AW + 1)'(1);
                2'b01:   fifoCount <= fifoCount - (AW + 1)'(1);
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    // A drop on the same edge as a clear wins, leaving exactly one counted drop.
    always_ff @(posedge clk40 or negedge resetn) begin
        if (!resetn) begin
            overflowFlag <= 1'b0;
            overflowCnt  <= '0;
        end else if (drop) begin
            overflowFlag <= 1'b1;
            if (clearOverflow) begin
                overflowCnt <= 8'd1;
            end else if (overflowCnt != 8'hFF) begin
                overflowCnt <= overflowCnt + 8'd1;
            end
        end else if (clearOverflow) begin
            overflowFlag <= 1'b0;
            overflowCnt  <= '0;
        end
    end

endmodule

// File: tb/tb_tdc_hit_readout.sv
// Self-checking bench for tdc_hit_readout: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model of the readout.
module tb_tdc_hit_readout;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk40 = 1'b0;
    logic          resetn = 1'b0;
    logic          enable = 1'b0;
    logic          bcReset = 1'b0;
    logic [9:0]    TOA_code = '0;
    logic [8:0]    TOT_code = '0;
    logic [9:0]    Cal_code = '0;
    logic          hitFlag = 1'b0;
    logic          TOAerrorFlag = 1'b0;
    logic          TOTerrorFlag = 1'b0;
    logic          CalerrorFlag = 1'b0;
    logic [9:0]    winLow = '0;
    logic [9:0]    winHigh = 10'd1023;
    logic          clearOverflow = 1'b0;
    logic [AW:0]   fifoCount;
    logic          overflowFlag;
    logic [7:0]    overflowCnt;

    tdc_hit_readout_if bus ();

    tdc_hit_readout #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk40        (clk40),
        .resetn       (resetn),
        .enable       (enable),
        .bcReset      (bcReset),
        .TOA_code     (TOA_code),
        .TOT_code     (TOT_code),
        .Cal_code     (Cal_code),
        .hitFlag      (hitFlag),
        .TOAerrorFlag (TOAerrorFlag),
        .TOTerrorFlag (TOTerrorFlag),
        .CalerrorFlag (CalerrorFlag),
        .winLow       (winLow),
        .winHigh      (winHigh),
        .clearOverflow(clearOverflow),
        .rd           (bus),
        .fifoCount    (fifoCount),
        .overflowFlag (overflowFlag),
        .overflowCnt  (overflowCnt)
    );

    always #5 clk40 = ~clk40;

    int checks = 0;
    int failures = 0;

    // Reference model
    logic [39:0] q[$];
    logic [7:0]  mBcid = '0;
    logic        mFlag = 1'b0;
    int          mCnt = 0;

    // Advance one clock: the model consumes the inputs present before the edge.
    task automatic cycle();
        logic [39:0] w;
        bit push, pop, drop;
        w    = {mBcid, TOAerrorFlag, TOTerrorFlag, CalerrorFlag, TOA_code, TOT_code, Cal_code};
        push = hitFlag && enable && (TOA_code >= winLow) && (TOA_code <= winHigh);
        pop  = (q.size() != 0) && bus.dataReady;
        drop = 1'b0;
        if (pop) void'(q.pop_front());
        if (push) begin
            if (q.size() < DEPTH) q.push_back(w);
            else drop = 1'b1;
        end
        if (drop) begin
            mFlag = 1'b1;
            mCnt  = clearOverflow ? 1 : ((mCnt == 255) ? 255 : mCnt + 1);
        end else if (clearOverflow) begin
            mFlag = 1'b0;
            mCnt  = 0;
        end
        mBcid = bcReset ? 8'd0 : mBcid + 8'd1;
        @(posedge clk40);
        #1;
    endtask

    task automatic setHit(input logic [9:0] toa);
        TOA_code     = toa;
        TOT_code     = 9'($urandom_range(0, 511));
        Cal_code     = 10'($urandom_range(0, 1023));
        TOAerrorFlag = 1'b0;
        TOTerrorFlag = 1'b0;
        CalerrorFlag = 1'b0;
        hitFlag      = 1'b1;
    endtask

    task automatic drain();
        bus.dataReady = 1'b1;
        hitFlag = 1'b0;
        for (int i = 0; i < 2 * DEPTH + 2 && q.size() != 0; i++) begin
            checks++;
            if (bus.dataOut !== q[0]) begin
                failures++;
                $display("FAIL drain_word got=%h exp=%h", bus.dataOut, q[0]);
            end
            cycle();
        end
        checks++;
        if (bus.dataValid !== 1'b0 || q.size() != 0) begin
            failures++;
            $display("FAIL drain_empty got_valid=%b model_left=%0d", bus.dataValid, q.size());
        end
    endtask

    task automatic test_reset();
        bus.dataReady = 1'b0;
        repeat (2) @(posedge clk40);
        #1;
        resetn = 1'b1;
        checks++;
        if (bus.dataValid !== 1'b0 || fifoCount !== '0 || bus.dataOut !== '0 ||
            overflowFlag !== 1'b0 || overflowCnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_state got v=%b cnt=%0d out=%h of=%b oc=%0d exp all zero",
                     bus.dataValid, fifoCount, bus.dataOut, overflowFlag, overflowCnt);
        end
        repeat (5) cycle();
        checks++;
        if (dut.bcid !== 8'd5 || dut.bcid !== mBcid) begin
            failures++;
            $display("FAIL bcid_count got=%0d exp=5", dut.bcid);
        end
        bcReset = 1'b1;
        cycle();
        bcReset = 1'b0;
        checks++;
        if (dut.bcid !== 8'd0) begin
            failures++;
            $display("FAIL bcid_reset got=%0d exp=0", dut.bcid);
        end
    endtask

    task automatic test_single_hit();
        logic [39:0] expWord;
        enable = 1'b1; winLow = 10'd0; winHigh = 10'd1023;
        repeat (7) cycle();
        checks++;
        if (dut.bcid !== 8'd7) begin
            failures++;
            $display("FAIL bcid_before_hit got=%0d exp=7", dut.bcid);
        end
        bus.dataReady = 1'b1;
        TOA_code = 10'd300; TOT_code = 9'd150; Cal_code = 10'd512;
        TOAerrorFlag = 1'b0; TOTerrorFlag = 1'b0; CalerrorFlag = 1'b0;
        hitFlag = 1'b1;
        cycle();
        hitFlag = 1'b0;
        expWord = {8'd7, 3'b000, 10'd300, 9'd150, 10'd512};
        checks++;
        if (bus.dataValid !== 1'b1 || bus.dataOut !== expWord || q.size() != 1 || q[0] !== expWord) begin
            failures++;
            $display("FAIL single_hit got v=%b out=%h exp v=1 out=%h", bus.dataValid, bus.dataOut, expWord);
        end
        cycle();
        checks++;
        if (bus.dataValid !== 1'b0 || fifoCount !== '0) begin
            failures++;
            $display("FAIL single_pop got v=%b cnt=%0d exp v=0 cnt=0", bus.dataValid, fifoCount);
        end
    endtask

    task automatic test_window();
        logic [9:0] toas [4];
        toas[0] = 10'd99; toas[1] = 10'd100; toas[2] = 10'd200; toas[3] = 10'd201;
        bus.dataReady = 1'b0;
        winLow = 10'd100; winHigh = 10'd200;
        for (int i = 0; i < 4; i++) begin
            setHit(toas[i]);
            cycle();
        end
        hitFlag = 1'b0;
        checks++;
        if (fifoCount !== 4'd2 || q.size() != 2) begin
            failures++;
            $display("FAIL window_count got=%0d exp=2", fifoCount);
        end
        drain();
        bus.dataReady = 1'b0;
        winLow = 10'd300; winHigh = 10'd200;
        for (int i = 0; i < 6; i++) begin
            setHit(10'($urandom_range(0, 1023)));
            cycle();
        end
        hitFlag = 1'b0;
        checks++;
        if (fifoCount !== '0 || bus.dataValid !== 1'b0) begin
            failures++;
            $display("FAIL window_inverted got=%0d exp=0", fifoCount);
        end
        winLow = 10'd0; winHigh = 10'd1023;
    endtask

    task automatic test_overflow();
        clearOverflow = 1'b1;
        cycle();
        clearOverflow = 1'b0;
        bus.dataReady = 1'b0;
        for (int i = 0; i < 10; i++) begin
            setHit(10'($urandom_range(0, 1023)));
            cycle();
        end
        hitFlag = 1'b0;
        checks++;
        if (fifoCount !== 4'd8 || overflowFlag !== 1'b1 || overflowCnt !== 8'd2 || mCnt != 2) begin
            failures++;
            $display("FAIL overflow_fill got cnt=%0d of=%b oc=%0d exp 8/1/2", fifoCount, overflowFlag, overflowCnt);
        end
        checks++;
        if (bus.dataOut !== q[0]) begin
            failures++;
            $display("FAIL overflow_head got=%h exp=%h", bus.dataOut, q[0]);
        end
        bus.dataReady = 1'b1;
        setHit(10'($urandom_range(0, 1023)));
        cycle();
        hitFlag = 1'b0;
        bus.dataReady = 1'b0;
        checks++;
        if (fifoCount !== 4'd8 || overflowCnt !== 8'd2) begin
            failures++;
            $display("FAIL full_push_pop got cnt=%0d oc=%0d exp 8/2", fifoCount, overflowCnt);
        end
        drain();
    endtask

    task automatic test_saturate();
        clearOverflow = 1'b1;
        cycle();
        clearOverflow = 1'b0;
        bus.dataReady = 1'b0;
        for (int i = 0; i < DEPTH + 300; i++) begin
            setHit(10'($urandom_range(0, 1023)));
            cycle();
        end
        hitFlag = 1'b0;
        checks++;
        if (overflowCnt !== 8'd255 || overflowFlag !== 1'b1 || mCnt != 255) begin
            failures++;
            $display("FAIL saturate got oc=%0d of=%b exp 255/1", overflowCnt, overflowFlag);
        end
        clearOverflow = 1'b1;
        cycle();
        checks++;
        if (overflowCnt !== 8'd0 || overflowFlag !== 1'b0) begin
            failures++;
            $display("FAIL clear got oc=%0d of=%b exp 0/0", overflowCnt, overflowFlag);
        end
        setHit(10'($urandom_range(0, 1023)));
        cycle();
        hitFlag = 1'b0;
        clearOverflow = 1'b0;
        checks++;
        if (overflowCnt !== 8'd1 || overflowFlag !== 1'b1 || mCnt != 1) begin
            failures++;
            $display("FAIL clear_with_drop got oc=%0d of=%b exp 1/1", overflowCnt, overflowFlag);
        end
        drain();
    endtask

    task automatic test_errors();
        bus.dataReady = 1'b0;
        setHit(10'($urandom_range(0, 1023)));
        TOAerrorFlag = 1'b1; CalerrorFlag = 1'b1;
        cycle();
        hitFlag = 1'b0; TOAerrorFlag = 1'b0; CalerrorFlag = 1'b0;
        checks++;
        if (bus.dataValid !== 1'b1 || bus.dataOut[31:29] !== 3'b101 || bus.dataOut !== q[0]) begin
            failures++;
            $display("FAIL error_flags got v=%b out=%h exp flags=101 word=%h", bus.dataValid, bus.dataOut, q[0]);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                winLow  = 10'($urandom_range(0, 1023));
                winHigh = 10'($urandom_range(0, 1023));
            end
            enable        = ($urandom_range(0, 9) != 0);
            bus.dataReady = ($urandom_range(0, 2) == 0);
            bcReset       = ($urandom_range(0, 30) == 0);
            clearOverflow = ($urandom_range(0, 40) == 0);
            setHit(10'($urandom_range(0, 1023)));
            hitFlag       = ($urandom_range(0, 1) == 1);
            TOAerrorFlag  = 1'($urandom_range(0, 1));
            TOTerrorFlag  = 1'($urandom_range(0, 1));
            CalerrorFlag  = 1'($urandom_range(0, 1));
            cycle();
            checks++;
            if (bus.dataValid !== (q.size() != 0) || fifoCount !== (AW + 1)'(q.size()) ||
                (q.size() != 0 && bus.dataOut !== q[0]) ||
                overflowFlag !== mFlag || overflowCnt !== 8'(mCnt) || dut.bcid !== mBcid) begin
                failures++;
                $display("FAIL random_cycle%0d got v=%b cnt=%0d of=%b oc=%0d bc=%0d exp cnt=%0d of=%b oc=%0d bc=%0d",
                         i, bus.dataValid, fifoCount, overflowFlag, overflowCnt, dut.bcid,
                         q.size(), mFlag, mCnt, mBcid);
            end
        end
        hitFlag = 1'b0; bcReset = 1'b0; clearOverflow = 1'b0; enable = 1'b1;
        winLow = 10'd0; winHigh = 10'd1023;
        drain();
    endtask

    task automatic test_async_reset();
        bus.dataReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            setHit(10'($urandom_range(0, 1023)));
            cycle();
        end
        hitFlag = 1'b0;
        checks++;
        if (fifoCount !== 4'd4) begin
            failures++;
            $display("FAIL pre_reset_count got=%0d exp=4", fifoCount);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (bus.dataValid !== 1'b0 || fifoCount !== '0 || dut.bcid !== 8'd0) begin
            failures++;
            $display("FAIL async_reset got v=%b cnt=%0d bc=%0d exp 0/0/0", bus.dataValid, fifoCount, dut.bcid);
        end
        q.delete();
        mBcid = '0; mFlag = 1'b0; mCnt = 0;
        @(posedge clk40);
        #1;
        resetn = 1'b1;
        cycle();
        checks++;
        if (dut.bcid !== mBcid || overflowCnt !== 8'd0 || bus.dataOut !== '0) begin
            failures++;
            $display("FAIL post_reset got bc=%0d oc=%0d out=%h exp bc=%0d", dut.bcid, overflowCnt, bus.dataOut, mBcid);
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_window();
        test_overflow();
        test_saturate();
        test_errors();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
